sine_period_meter: RTL and testbench

- Receive-side counterpart of the audio sine generator: consumes the same strobed 8-bit two's-complement sample stream.
- Detects positive-going zero crossings with hysteresis and measures the period in samples.
- Averages the period over 2^LOG_AVG cycles and reports it with a valid pulse, a lock flag and a loss-of-signal timeout.
- Sits after the generator or audio input path, for tone verification and frequency tracking.

---
 rtl/sine_period_meter.sv | 129 ++++++++++++
 tb/tb_sine_period_meter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_period_meter.sv
// sine_period_meter: measures the period of a strobed 8-bit signed tone.
// Positive-going zero crossings are detected with hysteresis, the period in
// samples is counted between crossings, and 2^LOG_AVG periods are averaged
// into period_out. A lock flag and a loss-of-signal timeout accompany it.
module sine_period_meter #(
   parameter int HYST       = 2,
   parameter int PERIOD_W   = 12,
   parameter int MAX_PERIOD = 4095,
   parameter int LOG_AVG    = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  step_in,
   input  logic signed [7:0]     sample_in,
   output logic [PERIOD_W-1:0]   period_out,
   output logic                  valid_out,
   output logic                  locked_out,
   output logic                  timeout_out
);

   localparam int ACC_W = PERIOD_W + LOG_AVG;
   localparam logic signed [7:0]   HYST_POS = 8'(HYST);
   localparam logic signed [7:0]   HYST_NEG = 8'(-HYST);
   localparam logic [PERIOD_W-1:0] CNT_LAST = PERIOD_W'(MAX_PERIOD - 1);
   localparam logic [LOG_AVG-1:0]  CYC_LAST = '1;

   typedef enum logic {SEEK_LOW, SEEK_HIGH} state_t;

   state_t               state;
   state_t               state_next;
   logic                 arm;
   logic                 crossing;
   logic                 expire;
   logic                 have_edge;
   logic [PERIOD_W-1:0]  cnt;
   logic [ACC_W-1:0]     acc;
   logic [LOG_AVG-1:0]   cyc;
   logic [PERIOD_W-1:0]  period;
   logic [ACC_W-1:0]     sum;

   // Average of 2^LOG_AVG accumulated periods, truncated toward zero.
   function automatic logic [PERIOD_W-1:0] avg_trunc(input logic [ACC_W-1:0] total);
      logic [ACC_W-1:0] shifted;
      shifted = total >> LOG_AVG;
      return shifted[PERIOD_W-1:0];
   endfunction

   // Period just completed: steps since the previous crossing, inclusive.
   assign period = cnt + PERIOD_W'(1);
   assign sum    = acc + ACC_W'(period);

   // Crossing detector state register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= SEEK_LOW;
      end else begin
         state <= state_next;
      end
   end

   // Next state: a timeout overrides everything, otherwise one hop per step.
   always_comb begin
      state_next = state;
      if (expire) begin
         state_next = SEEK_LOW;
      end else if (arm) begin
         state_next = SEEK_HIGH;
      end else if (crossing) begin
         state_next = SEEK_LOW;
      end
   end

   // Decode arm/crossing/expire events for the current strobe.
   always_comb begin
      arm      = 1'b0;
      crossing = 1'b0;
      if (step_in) begin
         case (state)
            SEEK_LOW:  arm      = (sample_in <= HYST_NEG);
            SEEK_HIGH: crossing = (sample_in >= HYST_POS);
            default:   ;
         endcase
      end
      expire = step_in && have_edge && !crossing && (cnt == CNT_LAST);
   end

   // Period counting, averaging, lock tracking and registered outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         have_edge   <= 1'b0;
         cnt         <= '0;
         acc         <= '0;
         cyc         <= '0;
         period_out  <= '0;
         valid_out   <= 1'b0;
         locked_out  <= 1'b0;
         timeout_out <= 1'b0;
      end else begin
         valid_out   <= 1'b0;
         timeout_out <= 1'b0;
         if (crossing) begin
            have_edge <= 1'b1;
            cnt       <= '0;
            if (have_edge) begin
               if (cyc == CYC_LAST) begin
                  period_out <= avg_trunc(sum);
                  valid_out  <= 1'b1;
                  locked_out <= 1'b1;
                  acc        <= '0;
                  cyc        <= '0;
               end else begin
                  acc <= sum;
                  cyc <= cyc + 1'b1;
               end
            end
         end else if (expire) begin
            have_edge   <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            cyc         <= '0;
            locked_out  <= 1'b0;
            timeout_out <= 1'b1;
         end else if (step_in && have_edge) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sine_period_meter.sv
// Testbench for sine_period_meter: directed tone/square/timeout/reset
// scenarios plus randomized streams, all compared every cycle against a
// queue-based reference model of the period meter.
module tb_sine_period_meter;

   localparam int HYST = 2;
   localparam int PW   = 12;
   localparam int MAXP = 4095;
   localparam int LOGA = 2;
   localparam int NAVG = 1 << LOGA;

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic                 step_in;
   logic signed [7:0]    sample_in;
   logic [PW-1:0]        period_out;
   logic                 valid_out;
   logic                 locked_out;
   logic                 timeout_out;

   sine_period_meter #(
      .HYST(HYST), .PERIOD_W(PW), .MAX_PERIOD(MAXP), .LOG_AVG(LOGA)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in), .sample_in(sample_in),
      .period_out(period_out), .valid_out(valid_out),
      .locked_out(locked_out), .timeout_out(timeout_out)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   // reference model: armed flag, steps since last crossing, queue of periods
   bit m_armed, m_have, m_locked, m_valid, m_to;
   int m_since, m_period;
   int m_q[$];

   int valid_cnt, to_cnt;
   int sine_tab[16] = '{0, 3, 5, 6, 7, 6, 5, 3, 0, -3, -5, -6, -7, -6, -5, -3};

   typedef struct {
      int p[4];
      int exp_period;
   } sq_vec_t;
   sq_vec_t sq_tab[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_armed = 0; m_have = 0; m_locked = 0; m_valid = 0; m_to = 0;
      m_since = 0; m_period = 0;
      m_q.delete();
   endtask

   task automatic model_step(input int s);
      int sum;
      m_valid = 0;
      m_to    = 0;
      if (m_armed && s >= HYST) begin
         m_armed = 0;
         if (m_have) begin
            m_q.push_back(m_since + 1);
            if (m_q.size() == NAVG) begin
               sum = 0;
               foreach (m_q[i]) sum += m_q[i];
               m_period = sum / NAVG;
               m_valid  = 1;
               m_locked = 1;
               m_q.delete();
            end
         end
         m_have  = 1;
         m_since = 0;
      end else begin
         if (!m_armed && s <= -HYST) m_armed = 1;
         if (m_have) begin
            if (m_since == MAXP - 1) begin
               m_to = 1; m_have = 0; m_since = 0; m_locked = 0; m_armed = 0;
               m_q.delete();
            end else begin
               m_since++;
            end
         end
      end
   endtask

   // one clock: drive at negedge, DUT updates at posedge, compare at negedge
   task automatic tick(input bit st, input int s);
      step_in   = st;
      sample_in = 8'(s);
      @(posedge clk_in);
      if (st) model_step(s);
      else begin
         m_valid = 0;
         m_to    = 0;
      end
      @(negedge clk_in);
      check("cycle_outputs", {17'd0, period_out, valid_out, locked_out, timeout_out},
            {17'd0, 12'(m_period), m_valid, m_locked, m_to});
      if (valid_out) valid_cnt++;
      if (timeout_out) to_cnt++;
   endtask

   task automatic do_reset();
      rst_in    = 1'b1;
      step_in   = 1'b1;
      sample_in = 8'sd20;
      @(posedge clk_in);
      model_reset();
      @(negedge clk_in);
      rst_in = 1'b0;
      check("reset_period", 32'(period_out), 0);
      check("reset_flags", {29'd0, valid_out, locked_out, timeout_out}, 0);
      valid_cnt = 0;
      to_cnt    = 0;
   endtask

   task automatic run_sine(input int nsteps, input int gap);
      for (int i = 0; i < nsteps; i++) begin
         tick(1, sine_tab[i % 16]);
         for (int g = 1; g < gap; g++) tick(0, int'($urandom_range(255)) - 128);
      end
   endtask

   // square wave: one period of p steps ending on the crossing sample
   task automatic square_period(input int p, input int amp);
      int lo;
      lo = p / 2;
      for (int j = 0; j < p - lo - 1; j++) tick(1, amp);
      for (int j = 0; j < lo; j++) tick(1, -amp);
      tick(1, amp);
   endtask

   initial begin
      int k;
      bit found;

      sq_tab[0] = '{p: '{10, 12, 14, 16}, exp_period: 13};
      sq_tab[1] = '{p: '{2, 2, 2, 2}, exp_period: 2};
      sq_tab[2] = '{p: '{3, 3, 3, 4}, exp_period: 3};
      sq_tab[3] = '{p: '{100, 101, 102, 104}, exp_period: 101};
      sq_tab[4] = '{p: '{4095, 4095, 4095, 4095}, exp_period: 4095};

      rst_in = 1'b1; step_in = 1'b0; sample_in = '0;
      model_reset();
      do_reset();

      // sine, full rate: 9 crossings -> 2 averages of 16
      run_sine(146, 1);
      check("sine_valid_count", 32'(valid_cnt), 2);
      check("sine_period", 32'(period_out), 16);
      check("sine_locked", 32'(locked_out), 1);

      // hold zero: timeout exactly 4095 steps after the last crossing
      k = 0; found = 0;
      while (k < 5000 && !found) begin
         tick(1, 0);
         k++;
         if (timeout_out) found = 1;
      end
      check("timeout_steps", found ? k : -1, 4095);
      check("timeout_unlock", 32'(locked_out), 0);
      check("timeout_keeps_period", 32'(period_out), 16);

      // resume: relock on the 5th crossing (index 81)
      valid_cnt = 0;
      run_sine(81, 1);
      check("relock_not_early", 32'(valid_cnt), 0);
      tick(1, sine_tab[81 % 16]);
      check("relock_valid", 32'(valid_out), 1);
      check("relock_period", 32'(period_out), 16);
      check("relock_locked", 32'(locked_out), 1);

      // sine strobed every 250 clocks
      do_reset();
      run_sine(146, 250);
      check("slow_valid_count", 32'(valid_cnt), 2);
      check("slow_period", 32'(period_out), 16);

      // +-1 noise never crosses with HYST=2
      do_reset();
      for (int i = 0; i < 200; i++) tick(1, (i % 2) ? 1 : -1);
      check("noise_valid", 32'(valid_cnt), 0);
      check("noise_timeout", 32'(to_cnt), 0);
      check("noise_locked", 32'(locked_out), 0);

      // reset after two measured periods discards partial work
      do_reset();
      run_sine(50, 1);
      do_reset();
      run_sine(81, 1);
      check("rst_no_stale_valid", 32'(valid_cnt), 0);
      tick(1, sine_tab[81 % 16]);
      check("rst_fifth_valid", 32'(valid_out), 1);
      check("rst_fifth_period", 32'(period_out), 16);

      // table-driven square waves
      for (int v = 0; v < 5; v++) begin
         do_reset();
         tick(1, -20);
         tick(1, 20);
         for (int n = 0; n < 4; n++) square_period(sq_tab[v].p[n], 20);
         check($sformatf("sq%0d_valid", v), 32'(valid_out), 1);
         check($sformatf("sq%0d_period", v), 32'(period_out), sq_tab[v].exp_period);
         check($sformatf("sq%0d_count", v), 32'(valid_cnt), 1);
         check($sformatf("sq%0d_locked", v), 32'(locked_out), 1);
      end

      // random square waves with random strobe gaps
      do_reset();
      for (int n = 0; n < 40; n++) begin
         int p, amp, lo;
         p   = $urandom_range(40, 2);
         amp = $urandom_range(100, 2);
         lo  = p / 2;
         for (int j = 0; j < p; j++) begin
            int s;
            s = (j >= p - lo - 1 && j < p - 1) ? -amp : amp;
            tick(1, s);
            for (int g = 0; g < int'($urandom_range(2)); g++) tick(0, int'($urandom_range(255)) - 128);
         end
      end

      // random samples around the hysteresis band
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(3) != 0, int'($urandom_range(12)) - 6);
      end

      // reset during random activity
      do_reset();
      for (int i = 0; i < 300; i++) tick(1, int'($urandom_range(40)) - 20);
      do_reset();
      for (int i = 0; i < 300; i++) tick(1, int'($urandom_range(40)) - 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
